// File: rtl/hl_bridge.sv
// ---------------------------------------------------------------------------
// hl_bridge
//
// Clock-domain-crossing bridge from the CPU load/store path (clk_h) to slow
// peripherals (clk_l). One transaction is in flight at a time. The request
// is parked in holding registers and announced by flipping req_tgl; the low
// side answers by flipping ack_tgl once the response registers are loaded.
// Only the two toggle bits pass through synchronisers. Every multi-bit
// value crossing a domain is guaranteed stable while the other side samples
// it, because the toggle that announces it is only seen after it settled.
//
// Parameters
//   DATA_W      data width in bits (multiple of 8)
//   ADDR_W      address width
//   SYNC_STAGES flops per synchroniser chain (2..4)
//   TIMEOUT     clk_l cycles to wait for l_ready in L_WAIT; 0 disables
//
// Ports (high side, clk_h)
//   clk_h, rst                  fast clock, async active-high reset (both domains)
//   h_read_en / h_write_en      level requests, held until h_ready
//   h_addr, h_wdata, h_wstrb    request payload
//   h_ready                     one-cycle completion pulse
//   h_rdata, h_err              response, non-zero only while h_ready=1
//   h_busy                      transaction crossing to the low side
// Ports (low side, clk_l)
//   clk_l                       slow peripheral clock
//   l_read_en / l_write_en      one-cycle strobes to the peripheral
//   l_addr, l_wdata, l_wstrb    payload, held from strobe until response
//   l_ready, l_rdata, l_err     peripheral completion and response
// ---------------------------------------------------------------------------
module hl_bridge #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk_h,
    input  logic                  rst,
    input  logic                  clk_l,
    // high side
    input  logic                  h_read_en,
    input  logic                  h_write_en,
    input  logic [ADDR_W-1:0]     h_addr,
    input  logic [DATA_W-1:0]     h_wdata,
    input  logic [DATA_W/8-1:0]   h_wstrb,
    output logic                  h_ready,
    output logic [DATA_W-1:0]     h_rdata,
    output logic                  h_err,
    output logic                  h_busy,
    // low side
    output logic                  l_read_en,
    output logic                  l_write_en,
    output logic [ADDR_W-1:0]     l_addr,
    output logic [DATA_W-1:0]     l_wdata,
    output logic [DATA_W/8-1:0]   l_wstrb,
    input  logic                  l_ready,
    input  logic [DATA_W-1:0]     l_rdata,
    input  logic                  l_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    localparam logic [1:0] H_IDLE  = 2'd0;
    localparam logic [1:0] H_REQ   = 2'd1;
    localparam logic [1:0] H_DONE  = 2'd2;

    localparam logic [1:0] L_IDLE  = 2'd0;
    localparam logic [1:0] L_ISSUE = 2'd1;
    localparam logic [1:0] L_WAIT  = 2'd2;
    localparam logic [1:0] L_ACK   = 2'd3;

    // high-side state
    logic [1:0]             h_state;
    logic                   req_tgl;
    logic                   ack_seen;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [ADDR_W-1:0]      hold_addr;
    logic [DATA_W-1:0]      hold_wdata;
    logic [STRB_W-1:0]      hold_wstrb;
    logic                   hold_write;

    // low-side state
    logic [1:0]             l_state;
    logic                   ack_tgl;
    logic                   req_seen;
    logic [SYNC_STAGES-1:0] req_sync;
    logic [CNT_W-1:0]       tmo_cnt;
    logic [DATA_W-1:0]      resp_rdata;
    logic                   resp_err;

    // -----------------------------------------------------------------------
    // High-side FSM (clk_h)
    // -----------------------------------------------------------------------
    // NOTE: all state below is updated with non-blocking assignments so every
    // flop samples pre-edge values; blocking here would collapse the
    // synchroniser chain into a single flop.
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            h_state    <= H_IDLE;
            req_tgl    <= 1'b0;
            ack_seen   <= 1'b0;
            ack_sync   <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_wstrb <= '0;
            hold_write <= 1'b0;
            h_ready    <= 1'b0;
            h_rdata    <= '0;
            h_err      <= 1'b0;
            h_busy     <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_tgl};

            case (h_state)
                H_IDLE: begin
                    if (h_read_en ^ h_write_en) begin
                        hold_addr  <= h_addr;
                        hold_wdata <= h_wdata;
                        hold_wstrb <= h_wstrb;
                        hold_write <= h_write_en;
                        req_tgl    <= ~req_tgl;
                        h_busy     <= 1'b1;
                        h_state    <= H_REQ;
                    end else if (h_read_en && h_write_en) begin
                        // Ambiguous request never reaches the peripheral.
                        h_ready <= 1'b1;
                        h_rdata <= '0;
                        h_err   <= 1'b1;
                        h_state <= H_DONE;
                    end
                end
                H_REQ: begin
                    // resp_* were loaded before ack_tgl flipped, so they are
                    // settled by the time the flip emerges from the chain.
                    if (ack_sync[SYNC_STAGES-1] != ack_seen) begin
                        ack_seen <= ack_sync[SYNC_STAGES-1];
                        h_rdata  <= resp_rdata;
                        h_err    <= resp_err;
                        h_ready  <= 1'b1;
                        h_busy   <= 1'b0;
                        h_state  <= H_DONE;
                    end
                end
                H_DONE: begin
                    h_ready <= 1'b0;
                    h_rdata <= '0;
                    h_err   <= 1'b0;
                    h_state <= H_IDLE;
                end
                default: h_state <= H_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Low-side FSM (clk_l)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            l_state    <= L_IDLE;
            ack_tgl    <= 1'b0;
            req_seen   <= 1'b0;
            req_sync   <= '0;
            tmo_cnt    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            l_read_en  <= 1'b0;
            l_write_en <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_wstrb    <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_tgl};

            case (l_state)
                L_IDLE: begin
                    // Payload and strobe are loaded on the way into L_ISSUE
                    // so the strobe is visible for exactly the L_ISSUE cycle.
                    if (req_sync[SYNC_STAGES-1] != req_seen) begin
                        req_seen   <= req_sync[SYNC_STAGES-1];
                        l_addr     <= hold_addr;
                        l_wdata    <= hold_wdata;
                        l_wstrb    <= hold_wstrb;
                        l_read_en  <= ~hold_write;
                        l_write_en <= hold_write;
                        l_state    <= L_ISSUE;
                    end
                end
                L_ISSUE: begin
                    // l_ready seen here is deliberately ignored.
                    l_read_en  <= 1'b0;
                    l_write_en <= 1'b0;
                    tmo_cnt    <= '0;
                    l_state    <= L_WAIT;
                end
                L_WAIT: begin
                    // A response arriving on the expiry cycle takes priority.
                    if (l_ready) begin
                        resp_rdata <= hold_write ? '0 : l_rdata;
                        resp_err   <= l_err;
                        l_state    <= L_ACK;
                    end else if ((TIMEOUT != 0) && (tmo_cnt == CNT_MAX)) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        l_state    <= L_ACK;
                    end else if (tmo_cnt != CNT_MAX) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                L_ACK: begin
                    ack_tgl <= ~ack_tgl;
                    l_addr  <= '0;
                    l_wdata <= '0;
                    l_wstrb <= '0;
                    l_state <= L_IDLE;
                end
                default: l_state <= L_IDLE;
            endcase
        end
    end

endmodule
